// File: rtl/hier_result_collector.sv
// Round-robin fan-in of child result beats onto one upstream stream, tagged with the source index.
// Define HIER_COLLECTOR_SKID_EN for a 2-entry output FIFO; otherwise a single output register.
module hier_result_collector #(
  parameter int unsigned N_SRC  = 10,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SRC_W  = $clog2(N_SRC)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [N_SRC-1:0]        src_valid_i,
  input  logic [N_SRC*DATA_W-1:0] src_data_i,
  output logic [N_SRC-1:0]        src_ready_o,
  output logic                    out_valid_o,
  output logic [DATA_W-1:0]       out_data_o,
  output logic [SRC_W-1:0]        out_src_o,
  input  logic                    out_ready_i,
  output logic [15:0]             beat_cnt_o
);

  logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [15:0]       beat_cnt_q, beat_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [SRC_W-1:0]  out_src_q, out_src_d;

  logic              gnt_found;
  logic [SRC_W-1:0]  gnt_idx;
  logic [SRC_W-1:0]  cand_idx;
  int unsigned       cand;
  logic              space, push, pop;
  logic [DATA_W-1:0] src_data_arr [N_SRC];
  logic [DATA_W-1:0] push_data;

  always_comb begin
    for (int unsigned i = 0; i < N_SRC; i++) begin
      src_data_arr[i] = src_data_i[i*DATA_W +: DATA_W];
    end
  end

  // Search starts at rr_ptr and wraps at N_SRC, never at 2^SRC_W.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      cand = 32'(rr_ptr_q) + k;
      if (cand >= N_SRC) cand = cand - N_SRC;
      cand_idx = SRC_W'(cand);
      if (!gnt_found && src_valid_i[cand_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand_idx;
      end
    end
  end

  assign push_data   = src_data_arr[gnt_idx];
  assign push        = rst_ni && gnt_found && space;
  assign pop         = out_valid_q && out_ready_i;
  assign src_ready_o = push ? (N_SRC'(1) << gnt_idx) : '0;

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    if (push) begin
      rr_ptr_d   = (gnt_idx == SRC_W'(N_SRC - 1)) ? '0 : gnt_idx + 1'b1;
      beat_cnt_d = beat_cnt_q + 16'd1;
    end
  end

`ifdef HIER_COLLECTOR_SKID_EN
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [SRC_W-1:0]  skid_src_q, skid_src_d;

  // Space depends only on registered state, so out_ready never reaches src_ready.
  assign space = !skid_valid_q;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_src_d    = out_src_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_src_d   = skid_src_q;
    if (pop) begin
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        out_src_d    = skid_src_q;
        skid_valid_d = 1'b0;
      end else if (push) begin
        out_data_d = push_data;
        out_src_d  = gnt_idx;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (push) begin
      if (!out_valid_q) begin
        out_valid_d = 1'b1;
        out_data_d  = push_data;
        out_src_d   = gnt_idx;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = push_data;
        skid_src_d   = gnt_idx;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_src_q   <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_src_q   <= skid_src_d;
    end
  end
`else
  assign space = !out_valid_q || out_ready_i;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (push) begin
      out_valid_d = 1'b1;
      out_data_d  = push_data;
      out_src_d   = gnt_idx;
    end else if (pop) begin
      out_valid_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr_q    <= '0;
      beat_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_src_o   = out_src_q;
  assign beat_cnt_o  = beat_cnt_q;

endmodule

// File: tb/tb_hier_result_collector.sv
// Scoreboard bench for hier_result_collector: a reference arbiter/occupancy model predicts
// src_ready and queues expected beats, which are popped and compared as the DUT emits them.
module tb_hier_result_collector;

  localparam int unsigned N  = 10;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
`ifdef HIER_COLLECTOR_SKID_EN
  localparam bit Skid = 1'b1;
`else
  localparam bit Skid = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  src_valid;
  logic [N*DW-1:0] src_data;
  logic [N-1:0]  src_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [SW-1:0] out_src;
  logic          out_ready;
  logic [15:0]   beat_cnt;

  logic [N-1:0]  mask;
  int unsigned   seq [N] = '{default: 32'd0};
  int unsigned   xfer_total = 0;
  int            n_checks = 0;
  int            n_fails  = 0;

  int            m_occ = 0;
  int            m_rr  = 0;
  logic [15:0]   m_cnt = '0;
  logic [SW+DW-1:0] sb [$];

  hier_result_collector #(
    .N_SRC  (N),
    .DATA_W (DW),
    .SRC_W  (SW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .src_valid_i (src_valid),
    .src_data_i  (src_data),
    .src_ready_o (src_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_src_o   (out_src),
    .out_ready_i (out_ready),
    .beat_cnt_o  (beat_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign src_valid = mask;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      src_data[i*DW +: DW] = DW'(32'hA0 + i + (seq[i] << 8));
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Producer side: advance a source's payload only once the DUT took it.
  always @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < N; i++) begin
        if (src_valid[i] && src_ready[i]) begin
          seq[i]     <= seq[i] + 1;
          xfer_total <= xfer_total + 1;
        end
      end
    end
  end

  // Reference model, evaluated mid-cycle for the upcoming rising edge.
  always @(negedge clk) begin : model
    int g;
    int c;
    bit found;
    bit sp;
    bit pop;
    logic [N-1:0] exp_rdy;
    logic [SW+DW-1:0] e;
    if (!rst_n) begin
      check_eq("rdy_in_reset", src_ready, '0);
      m_occ = 0;
      m_rr  = 0;
      m_cnt = '0;
      sb.delete();
    end else begin
      check_eq("out_valid", out_valid, m_occ != 0);
      check_eq("beat_cnt", beat_cnt, m_cnt);
      sp = Skid ? (m_occ < 2) : (m_occ == 0 || out_ready);
      found = 1'b0;
      g = 0;
      for (int k = 0; k < N; k++) begin
        c = (m_rr + k) % N;
        if (!found && src_valid[c]) begin
          found = 1'b1;
          g = c;
        end
      end
      exp_rdy = (found && sp) ? (N'(1) << g) : '0;
      check_eq("src_ready", src_ready, exp_rdy);
      pop = (m_occ != 0) && out_ready;
      if (pop) begin
        check_eq("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check_eq("out_src", out_src, e[SW+DW-1:DW]);
          check_eq("out_data", out_data, e[DW-1:0]);
        end
      end
      if (found && sp) begin
        sb.push_back({SW'(g), src_data[g*DW +: DW]});
        m_rr  = (g == N - 1) ? 0 : g + 1;
        m_cnt = m_cnt + 16'd1;
      end
      m_occ = m_occ + ((found && sp) ? 1 : 0) - (pop ? 1 : 0);
    end
  end

  initial begin : stim
    int unsigned x0;
    int guard;
    int wrap_order [4] = '{9, 3, 9, 3};
    logic [15:0] wrap_exp [3] = '{16'hFFFF, 16'h0000, 16'h0001};

    rst_n     = 1'b0;
    out_ready = 1'b1;
    mask      = '1;

    // Reset held with every source requesting.
    repeat (3) begin
      @(posedge clk); #3;
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_beat_cnt", beat_cnt, 0);
      check_eq("rst_src_ready", src_ready, 0);
    end
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_out_src", out_src, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #2;
    check_eq("first_grant", src_ready, 1);

    // Round-robin fairness across all sources.
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 20) mask = '0;
      #2;
      check_eq("rr_out_src", out_src, (k - 1) % N);
    end
    check_eq("rr_beat_cnt", beat_cnt, 20);
    repeat (3) @(posedge clk);

    // Pointer wrap and skip: move pointer to 4, then only 3 and 9 request.
    @(posedge clk); #1;
    mask = N'(1) << 3;
    #2;
    check_eq("wrap_setup", src_ready, N'(1) << 3);
    for (int j = 0; j < 4; j++) begin
      @(posedge clk); #1;
      mask = (N'(1) << 3) | (N'(1) << 9);
      #2;
      check_eq("wrap_grant", src_ready, N'(1) << wrap_order[j]);
    end
    @(posedge clk); #1;
    mask = '0;
    repeat (3) @(posedge clk);

    // Backpressure with sources 1 and 2.
    @(posedge clk); #1;
    out_ready = 1'b0;
    mask = (N'(1) << 1) | (N'(1) << 2);
    x0 = xfer_total;
    repeat (5) @(posedge clk);
    #1;
    check_eq("bp_accepted", xfer_total - x0, Skid ? 2 : 1);
    check_eq("bp_ready_low", src_ready, 0);
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    mask = '0;
    repeat (4) @(posedge clk);

    // Counter wrap.
    #1;
    mask = N'(1);
    guard = 0;
    while (m_cnt != 16'hFFFE && guard < 70000) begin
      @(posedge clk); #3;
      guard++;
    end
    check_eq("cnt_preload", beat_cnt, 16'hFFFE);
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #3;
      check_eq("cnt_wrap", beat_cnt, wrap_exp[j]);
    end

    // Reset while the output stage holds beats.
    @(posedge clk); #1;
    out_ready = 1'b0;
    mask = (N'(1) << 5) | (N'(1) << 6);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    mask = '1;
    out_ready = 1'b1;
    #2;
    check_eq("mid_rst_out_valid", out_valid, 0);
    check_eq("mid_rst_beat_cnt", beat_cnt, 0);
    check_eq("mid_rst_grant", src_ready, 1);
    repeat (5) @(posedge clk);
    #1;
    mask = '0;
    repeat (5) @(posedge clk);
    #3;
    check_eq("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/hier_result_collector.md
# hier_result_collector

Collects result beats from up to N_SRC child instances in a generated module hierarchy and merges them onto one upstream stream. Arbitration is round-robin, and each output beat carries the index of the child that sent it. The block sits in a parent module, between its child instances and the parent's own upstream port. It is the fan-in counterpart to the parent's fan-out instantiation of children.

## Interface
Parameters:
- N_SRC, 10, number of child sources (2..16)
- DATA_W, 32, payload width per beat
- SRC_W, $clog2(N_SRC), width of the source index

Ports:
- clk  in  1  single clock; all logic on its rising edge
- rst_n  in  1  synchronous, active-low reset
- src_valid  in  N_SRC  per-child valid
- src_data  in  N_SRC*DATA_W  per-child payload; child i occupies bits [i*DATA_W +: DATA_W]
- src_ready  out  N_SRC  per-child accept; at most one bit high per cycle
- out_valid  out  1  upstream beat valid
- out_data  out  DATA_W  upstream payload
- out_src  out  SRC_W  index of the child that produced the beat
- out_ready  in  1  upstream accept
- beat_cnt  out  16  count of beats accepted from children; wraps at 16'hFFFF -> 0

## Operation
- Handshake rules, both sides:
  - A transfer occurs when valid && ready are high in the same cycle.
  - A producer holds valid and data stable until the transfer.
  - A producer does not deassert valid without a transfer.
- Space:
  - space = 1 when the output stage can take a beat this cycle (definition depends on configuration).
- Arbitration:
  - Round-robin pointer rr_ptr (SRC_W bits), reset value 0.
  - Search order is rr_ptr, rr_ptr+1, ..., N_SRC-1, 0, ..., rr_ptr-1.
  - The first valid source in that order is granted, but only if space = 1.
  - src_ready[g] = 1 for the granted g only; src_ready is combinational from src_valid, rr_ptr and space.
- Pointer update:
  - On a transfer from source g, rr_ptr <= g+1, wrapping N_SRC-1 -> 0 (not 2^SRC_W-1 -> 0).
  - With no grant, rr_ptr holds.
- Accepted beat:
  - Each accepted beat enters the output stage with out_src = g.
  - beat_cnt increments by 1 on every child-side transfer.
- Beats leave in acceptance order. No reordering, duplication or drops.
- No state machine beyond the pointer and the output-stage occupancy.
- Reset values:
  - out_valid = 0
  - out_data = 0
  - out_src = 0
  - beat_cnt = 0
  - rr_ptr = 0
  - src_ready = 0, during reset cycles regardless of src_valid
- Reset mid-operation:
  - Buffered beats are discarded.
  - Pointer and counter clear.
  - The first cycle after rst_n rises behaves as a fresh start.

## Timing
- Latency: a child beat accepted in cycle t appears on out_valid in cycle t+1 at the earliest.
- Throughput: one beat per cycle sustained while out_ready = 1.
- Simultaneous events in one cycle: an output drain and a child accept both occur, and occupancy is unchanged.
- Backpressure:
  - While out_ready = 0 and the stage is full, all src_ready = 0.
  - Pointer and counter hold.
- All outputs are registered except src_ready.

## Configuration
- Macro HIER_COLLECTOR_SKID_EN selects the output stage.
- Defined:
  - Output stage is a 2-entry FIFO.
  - space = !full, which depends only on registered state; there is no combinational path from out_ready to src_ready.
  - After out_ready deasserts, up to 2 beats are held.
  - Full throughput is retained across a single-cycle stall.
- Undefined:
  - Output stage is a single register.
  - space = !out_valid || out_ready, a combinational path from out_ready to src_ready.
  - At most 1 beat is held.
- Both builds produce identical beat order, out_src values and beat_cnt for the same accepted sequence.

## Test plan
- Reset: hold rst_n = 0 for 3 cycles with all src_valid = 1.
  - Required: src_ready = 0, out_valid = 0, beat_cnt = 0 throughout.
  - After release, the first grant goes to source 0.
- Round-robin fairness: all 10 sources continuously valid, payload = 32'hA0+i, out_ready = 1.
  - Required: out_src sequence 0,1,...,9,0,1, one beat per cycle.
  - beat_cnt = 20 after 20 beats.
- Pointer wrap and skip: only sources 3 and 9 valid, rr_ptr = 4.
  - Required: grant order 9, 3, 9, 3.
  - rr_ptr goes 4 -> 0 -> 4 after the first two grants, never reaching 10..15.
- Backpressure: out_ready = 0 for 5 cycles with sources 1 and 2 valid.
  - SKID build: exactly 2 beats accepted (src 1, src 2), then all src_ready = 0.
  - Non-SKID build: exactly 1 beat accepted.
  - On release, beats emerge in order with data intact and none lost.
- Counter wrap: preload traffic until beat_cnt = 16'hFFFE, then send 3 more beats.
  - Required: beat_cnt reads FFFF, 0000, 0001.
- Reset mid-stream: assert rst_n = 0 for 1 cycle while the output stage holds beats.
  - Required: out_valid = 0 the next cycle, beat_cnt = 0, rr_ptr = 0.
  - No stale beat appears after release.
